// File: rtl/umix_pkg.sv
// Shared types and constants for the serial word receiver.
// Holds the receiver state encoding and accumulator modes.
package umix_pkg;

    localparam int DEFAULT_SIZE = 32;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } rx_state_t;

    localparam logic [1:0] SR_HOLD  = 2'b00;
    localparam logic [1:0] SR_SHIFT = 2'b10;
    localparam logic [1:0] SR_ZERO  = 2'b11;

endpackage

// File: rtl/serial_word_rx_shift_reg.sv
// Right-shifting accumulator with serial MSB entry.
// Modes: shift right, parallel load of zero, hold.
module shift_reg #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             din,
    output logic [width-1:0] q
);

    // Apply the selected mode; unused encodings hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            case (mode)
                2'b10:   q <= {din, q[width-1:1]};
                2'b11:   q <= '0;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver, LSB first.
// One-deep skid in the accumulator when q is still occupied.
module serial_word_rx
    import umix_pkg::*;
#(
    parameter int size = DEFAULT_SIZE
) (
    input  logic            clk,
    input  logic            r,
    input  logic            si,
    input  logic            si_valid,
    output logic            si_ready,
    input  logic            clr,
    output logic [size-1:0] q,
    output logic            q_valid,
    input  logic            q_ready
);

    localparam int CW = $clog2(size + 1);
    localparam logic [CW-1:0] LAST = CW'(size - 1);

    rx_state_t       state;
    rx_state_t       state_nxt;
    logic [CW-1:0]   count;
    logic [size-1:0] acc;
    logic [1:0]      mode;
    logic            accept;
    logic            last;
    logic            free;
    logic            handshake;
    logic            load_new;
    logic            load_hold;

    shift_reg #(
        .width (size)
    ) u_acc (
        .clk  (clk),
        .rst  (r),
        .mode (mode),
        .din  (si),
        .q    (acc)
    );

    // State register.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake and accumulator control.
    always_comb begin
        state_nxt = state;
        si_ready  = 1'b0;
        mode      = SR_HOLD;
        accept    = 1'b0;
        last      = 1'b0;
        load_new  = 1'b0;
        load_hold = 1'b0;
        free      = !q_valid || q_ready;
        handshake = q_valid && q_ready;
        unique case (state)
            COLLECT: begin
                si_ready = !r;
                accept   = si_valid && si_ready;
                last     = accept && (count == LAST);
                if (clr) begin
                    mode = SR_ZERO;
                end else if (accept) begin
                    mode = SR_SHIFT;
                    if (last) begin
                        if (free) begin
                            load_new = 1'b1;
                        end else begin
                            state_nxt = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (clr) begin
                    mode      = SR_ZERO;
                    state_nxt = COLLECT;
                end else if (handshake) begin
                    load_hold = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // Bit counter; a clear outranks an accepted bit.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (accept) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

    // Output register: fresh word, held word, or drain.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (load_new) begin
            q       <= {si, acc[size-1:1]};
            q_valid <= 1'b1;
        end else if (load_hold) begin
            q       <= acc;
            q_valid <= 1'b1;
        end else if (handshake) begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_word_rx.sv
// Randomized bench for serial_word_rx with a bit-queue model.
// Directed word scenarios plus a random soak.
module tb_serial_word_rx;

    logic        clk = 1'b0;
    logic        r;
    logic        si;
    logic        si_valid;
    logic        si_ready;
    logic        clr;
    logic [31:0] q;
    logic        q_valid;
    logic        q_ready;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    int          m_n;
    logic [31:0] m_part;
    logic [31:0] m_q;
    logic        m_qv;
    logic        m_held;
    logic [31:0] m_held_word;

    serial_word_rx #(.size(32)) dut (
        .clk      (clk),
        .r        (r),
        .si       (si),
        .si_valid (si_valid),
        .si_ready (si_ready),
        .clr      (clr),
        .q        (q),
        .q_valid  (q_valid),
        .q_ready  (q_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n         = 0;
        m_part      = '0;
        m_q         = '0;
        m_qv        = 1'b0;
        m_held      = 1'b0;
        m_held_word = '0;
    endtask

    task automatic model_edge(input logic b, input logic v,
                              input logic c, input logic qr);
        logic        hs;
        logic        was_held;
        logic        done;
        logic [31:0] w;
        hs       = m_qv && qr;
        was_held = m_held;
        done     = 1'b0;
        w        = '0;
        if (c) begin
            m_n    = 0;
            m_part = '0;
            m_held = 1'b0;
        end else if (v && !was_held) begin
            m_part[m_n] = b;
            m_n++;
            if (m_n == 32) begin
                done   = 1'b1;
                w      = m_part;
                m_n    = 0;
                m_part = '0;
            end
        end
        if (done) begin
            if (!m_qv || qr) begin
                m_q  = w;
                m_qv = 1'b1;
            end else begin
                m_held      = 1'b1;
                m_held_word = w;
            end
        end else if (was_held && hs && !c) begin
            m_q    = m_held_word;
            m_held = 1'b0;
            m_qv   = 1'b1;
        end else if (hs) begin
            m_qv = 1'b0;
        end
    endtask

    task automatic step(input logic b, input logic v,
                        input logic c, input logic qr);
        si       = b;
        si_valid = v;
        clr      = c;
        q_ready  = qr;
        #1;
        check("si_ready", {31'b0, si_ready}, {31'b0, !m_held});
        @(posedge clk);
        model_edge(b, v, c, qr);
        #1;
        check("q", q, m_q);
        check("q_valid", {31'b0, q_valid}, {31'b0, m_qv});
        check("count", 32'(dut.count), 32'(m_n));
    endtask

    task automatic send_bits(input logic [31:0] w, input int lo,
                             input int hi, input logic qr,
                             input int gap_pct);
        for (int i = lo; i <= hi; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                step(1'($urandom), 1'b0, 1'b0, qr);
            end
            step(w[i], 1'b1, 1'b0, qr);
        end
    endtask

    task automatic drain();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        r        = 1'b1;
        si       = 1'b0;
        si_valid = 1'b0;
        clr      = 1'b0;
        q_ready  = 1'b0;
        model_reset();
        #1;
        check("rst_q", q, 32'h0);
        check("rst_qv", {31'b0, q_valid}, 32'h0);
        check("rst_si_ready", {31'b0, si_ready}, 32'h0);
        check("rst_count", 32'(dut.count), 32'h0);
        #11;
        r = 1'b0;

        // Straight word with consumer ready.
        drain();
        send_bits(32'hDEADBEEF, 0, 31, 1'b1, 0);
        check("deadbeef_q", q, 32'hDEADBEEF);
        check("deadbeef_qv", {31'b0, q_valid}, 32'h1);

        // Two words back to back with consumer stalled.
        drain();
        send_bits(32'h11111111, 0, 31, 1'b0, 0);
        send_bits(32'h22222222, 0, 31, 1'b0, 0);
        check("hold_q", q, 32'h11111111);
        check("hold_si_ready", {31'b0, si_ready}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("unhold_q", q, 32'h22222222);
        check("unhold_qv", {31'b0, q_valid}, 32'h1);
        check("unhold_si_ready", {31'b0, si_ready}, 32'h1);

        // Last bit lands on the same edge as a q handshake.
        drain();
        send_bits(32'h0F0F0F0F, 0, 31, 1'b0, 0);
        check("pre_a5_q", q, 32'h0F0F0F0F);
        send_bits(32'hA5A5A5A5, 0, 30, 1'b0, 0);
        send_bits(32'hA5A5A5A5, 31, 31, 1'b1, 0);
        check("a5_q", q, 32'hA5A5A5A5);
        check("a5_qv", {31'b0, q_valid}, 32'h1);

        // Clear discards a partial word and its own bit.
        drain();
        send_bits($urandom, 0, 9, 1'b1, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("clr_count", 32'(dut.count), 32'h0);
        send_bits(32'h12345678, 0, 31, 1'b1, 0);
        check("clr_q", q, 32'h12345678);
        check("clr_qv", {31'b0, q_valid}, 32'h1);

        // Asynchronous reset mid-word with q occupied.
        drain();
        send_bits($urandom, 0, 31, 1'b0, 0);
        send_bits($urandom, 0, 16, 1'b0, 0);
        check("pre_rst_qv", {31'b0, q_valid}, 32'h1);
        #2 r = 1'b1;
        #1;
        check("arst_q", q, 32'h0);
        check("arst_qv", {31'b0, q_valid}, 32'h0);
        check("arst_si_ready", {31'b0, si_ready}, 32'h0);
        check("arst_count", 32'(dut.count), 32'h0);
        #1 r = 1'b0;
        model_reset();
        send_bits(32'hCAFEF00D, 0, 31, 1'b1, 0);
        check("cafe_q", q, 32'hCAFEF00D);
        check("cafe_qv", {31'b0, q_valid}, 32'h1);

        // Word with random gaps on si_valid.
        drain();
        send_bits(32'h80000001, 0, 31, 1'b1, 40);
        check("gap_q", q, 32'h80000001);
        check("gap_qv", {31'b0, q_valid}, 32'h1);

        // Random soak against the model.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom),
                 1'($urandom_range(99) < 70),
                 1'($urandom_range(99) < 3),
                 1'($urandom_range(99) < 50));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_word_rx.md
SERIAL_WORD_RX -- requirements
Module: serial_word_rx

Interface
REQ-001 The block SHALL have parameter size, default 32, giving the assembled word width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port r, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port si, input, 1 bit: serial data bit, LSB of each word first.
REQ-005 The block SHALL have port si_valid, input, 1 bit: si carries a valid bit this cycle.
REQ-006 The block SHALL have port si_ready, output, 1 bit: the block accepts si this cycle.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous discard of the partial word.
REQ-008 The block SHALL have port q, output, size bits: the assembled word.
REQ-009 The block SHALL have port q_valid, output, 1 bit: q holds an unconsumed word.
REQ-010 The block SHALL have port q_ready, input, 1 bit: the consumer takes q this cycle.

Function
REQ-011 A bit SHALL be accepted on a rising edge where si_valid and si_ready are both 1.
REQ-012 An accepted bit SHALL shift the accumulator right with si entering the MSB (acc <= {si, acc[size-1:1]}), and the bit count SHALL increment.
REQ-013 The block SHALL implement two states: COLLECT (si_ready=1) and HOLD (si_ready=0, accumulator holds a complete word).
REQ-014 The output register SHALL be free when q_valid=0 or q_ready=1.
REQ-015 When the size-th bit is accepted and the output register is free, q SHALL load {si, acc[size-1:1]} on that same edge, q_valid SHALL be 1, the count SHALL reset to 0, and the state SHALL stay COLLECT (latency: q_valid rises 1 edge after the last bit is sampled).
REQ-016 When the size-th bit is accepted and the output register is not free, the completed word SHALL stay in the accumulator, the state SHALL go to HOLD, and the count SHALL reset to 0.
REQ-017 In HOLD, on the edge where q_valid=1 and q_ready=1, q SHALL load the accumulator, q_valid SHALL remain 1, and the state SHALL return to COLLECT.
REQ-018 A handshake on q with no new word loading SHALL clear q_valid on that edge.
REQ-019 q SHALL hold its value while q_valid=1 and q_ready=0; no word SHALL ever be overwritten or dropped.
REQ-020 clr=1 SHALL zero the count and accumulator and force COLLECT, including discarding a word held in HOLD; clr SHALL take priority over bit acceptance in the same cycle; q and q_valid SHALL be unaffected.
REQ-021 si_valid=0 cycles (gaps) SHALL leave count and accumulator unchanged.
REQ-022 The count SHALL be $clog2(size+1) bits wide and SHALL never exceed size-1 at rest.

Reset
REQ-023 While r=1, the block SHALL drive q=0, q_valid=0, si_ready=0, count=0, accumulator=0, and state=COLLECT, independent of clk.
REQ-024 After r deasserts, the first accepted bit SHALL be bit 0 of a new word; a partial word at reset time SHALL be lost.

Structure
REQ-025 The state typedef rx_state_t {COLLECT, HOLD} SHALL live in the shared package umix_pkg; the default width of 32 SHALL be a package constant.
REQ-026 The accumulator SHALL be one shift_reg instance used in these modes: 2'b10 shift right, 2'b11 parallel load zero (clr), 2'b00 hold.
REQ-027 The block SHALL contain no other sub-module.

Verification
REQ-028 Bench SHALL cover: 32 consecutive bits of 0xDEADBEEF LSB-first with q_ready=1 -> q_valid=1 and q=0xDEADBEEF on the edge after the 32nd bit.
REQ-029 Bench SHALL cover: 0x11111111 then 0x22222222 with q_ready=0 -> q=0x11111111, si_ready=0 after the 64th bit; q_ready=1 for one cycle -> q=0x22222222, q_valid stays 1, si_ready=1.
REQ-030 Bench SHALL cover: last bit of 0xA5A5A5A5 accepted on the same edge as a q handshake of 0x0F0F0F0F -> q=0xA5A5A5A5, q_valid=1, no word lost.
REQ-031 Bench SHALL cover: 10 random bits, clr for one cycle, then 0x12345678 -> q=0x12345678 only; clr asserted with si_valid=1 -> that bit is ignored.
REQ-032 Bench SHALL cover: r pulsed asynchronously mid-word (bit 17) and with q_valid=1 -> outputs zero immediately; the next 32 bits of 0xCAFEF00D -> q=0xCAFEF00D.
REQ-033 Bench SHALL cover: 0x80000001 sent with random si_valid gaps -> q=0x80000001, with the count unchanged across every gap.
